inst_block_fetcher: RTL and testbench

AXI4 read master that fills the double-buffered instruction memory one block at a time. It is the producer side of the imem write interface. On each imem_wr_start request it fetches the next instruction block from DRAM, splits it into bursts, streams the beats out on imem_wr_data/imem_wr_data_valid, then pulses imem_wr_done. It sits between the AXI interconnect and the instruction memory, and is configured once per program through the start/cfg ports.

---
 rtl/inst_block_fetcher.sv | 219 +++++++++++++++++++++
 tb/tb_inst_block_fetcher.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_block_fetcher.sv
// AXI4 read master that streams one instruction block per imem_wr_start into the imem write port.
// Optional performance counters are enabled with the INST_FETCH_PERF_CNT_EN macro.
module inst_block_fetcher #(
  parameter int unsigned NUM_INST_IN     = 2,
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_ID_WIDTH    = 1,
  parameter int unsigned MAX_BURST_LEN   = 16,
  parameter int unsigned BLOCK_LEN_WIDTH = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [AXI_ADDR_WIDTH-1:0]              cfg_base_addr,
  input  logic [BLOCK_LEN_WIDTH-1:0]             cfg_block_len,
  input  logic [BLOCK_LEN_WIDTH-1:0]             cfg_num_blocks,
  input  logic                                   imem_wr_start,
  output logic                                   imem_wr_done,
  output logic                                   imem_wr_data_valid,
  output logic [NUM_INST_IN*INST_DATA_WIDTH-1:0] imem_wr_data,
  output logic [AXI_ID_WIDTH-1:0]                m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]              m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  output logic [2:0]                             m_axi_arsize,
  output logic [1:0]                             m_axi_arburst,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  input  logic [NUM_INST_IN*INST_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready,
`ifdef INST_FETCH_PERF_CNT_EN
  output logic [31:0]                            perf_beat_cnt,
  output logic [31:0]                            perf_stall_cnt,
`endif
  output logic                                   fetch_busy,
  output logic                                   all_blocks_done,
  output logic                                   rresp_err
);

  localparam int unsigned DW             = NUM_INST_IN * INST_DATA_WIDTH;
  localparam int unsigned BYTES_PER_BEAT = DW / 8;
  localparam int unsigned SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
  localparam int unsigned CW             = (BLOCK_LEN_WIDTH > 13) ? BLOCK_LEN_WIDTH : 13;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_ADDR     = 3'd2,
    S_DATA     = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [BLOCK_LEN_WIDTH-1:0] blk_cnt_q, blk_cnt_d;
  logic [BLOCK_LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [BLOCK_LEN_WIDTH-1:0] block_len_q, block_len_d;
  logic [BLOCK_LEN_WIDTH-1:0] num_blocks_q, num_blocks_d;
  logic                       all_done_q, all_done_d;
  logic                       rresp_err_q, rresp_err_d;
  logic [CW-1:0]              to_4k_beats;
  logic [CW-1:0]              burst_beats;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      blk_cnt_q    <= '0;
      remaining_q  <= '0;
      block_len_q  <= '0;
      num_blocks_q <= '0;
      all_done_q   <= 1'b0;
      rresp_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      blk_cnt_q    <= blk_cnt_d;
      remaining_q  <= remaining_d;
      block_len_q  <= block_len_d;
      num_blocks_q <= num_blocks_d;
      all_done_q   <= all_done_d;
      rresp_err_q  <= rresp_err_d;
    end
  end

  // Burst size: limited by what is left, the max burst and the next 4KB page edge
  always_comb begin
    to_4k_beats = CW'((13'h1000 - {1'b0, cur_addr_q[11:0]}) >> SIZE_LOG2);
    burst_beats = CW'(MAX_BURST_LEN);
    if (CW'(remaining_q) < burst_beats) burst_beats = CW'(remaining_q);
    if (to_4k_beats < burst_beats) burst_beats = to_4k_beats;
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    blk_cnt_d    = blk_cnt_q;
    remaining_d  = remaining_q;
    block_len_d  = block_len_q;
    num_blocks_d = num_blocks_q;
    all_done_d   = all_done_q;
    rresp_err_d  = rresp_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          block_len_d  = cfg_block_len;
          num_blocks_d = cfg_num_blocks;
          cur_addr_d   = cfg_base_addr;
          blk_cnt_d    = '0;
          rresp_err_d  = 1'b0;
          if (cfg_num_blocks == '0) begin
            all_done_d = 1'b1;
          end else begin
            all_done_d = 1'b0;
            state_d    = S_WAIT_REQ;
          end
        end
      end
      S_WAIT_REQ: begin
        if (imem_wr_start) begin
          remaining_d = block_len_q;
          state_d     = (block_len_q == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          cur_addr_d  = cur_addr_q + (AXI_ADDR_WIDTH'(burst_beats) << SIZE_LOG2);
          remaining_d = remaining_q - BLOCK_LEN_WIDTH'(burst_beats);
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) rresp_err_d = 1'b1;
          // The slave's rlast decides the burst end; remaining only tracks issued beats
          if (m_axi_rlast) state_d = (remaining_q != '0) ? S_ADDR : S_DONE;
        end
      end
      S_DONE: begin
        blk_cnt_d = blk_cnt_q + BLOCK_LEN_WIDTH'(1);
        if (blk_cnt_d == num_blocks_q) begin
          all_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the R channel passes straight through to imem
  always_comb begin
    m_axi_arvalid      = 1'b0;
    m_axi_araddr       = '0;
    m_axi_arlen        = 8'd0;
    m_axi_rready       = 1'b0;
    imem_wr_data_valid = 1'b0;
    imem_wr_data       = '0;
    imem_wr_done       = 1'b0;
    case (state_q)
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = cur_addr_q;
        m_axi_arlen   = 8'(burst_beats - CW'(1));
      end
      S_DATA: begin
        m_axi_rready       = 1'b1;
        imem_wr_data_valid = m_axi_rvalid;
        if (m_axi_rvalid) imem_wr_data = m_axi_rdata;
      end
      S_DONE: imem_wr_done = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_arid      = '0;
  assign m_axi_arsize    = 3'(SIZE_LOG2);
  assign m_axi_arburst   = 2'b01;
  assign fetch_busy      = (state_q != S_IDLE);
  assign all_blocks_done = all_done_q;
  assign rresp_err       = rresp_err_q;

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] perf_beat_q, perf_beat_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_beat_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_beat_q  <= perf_beat_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  // Beat and stall accounting, restarted by an accepted start
  always_comb begin
    perf_beat_d  = perf_beat_q;
    perf_stall_d = perf_stall_q;
    if (state_q == S_IDLE && start) begin
      perf_beat_d  = '0;
      perf_stall_d = '0;
    end
    if (state_q == S_DATA && m_axi_rvalid) perf_beat_d = perf_beat_q + 32'd1;
    if ((state_q == S_ADDR && !m_axi_arready) || (state_q == S_DATA && !m_axi_rvalid))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  assign perf_beat_cnt  = perf_beat_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_block_fetcher.sv
// Directed bench for inst_block_fetcher: AXI slave model, scoreboard queues for AR and imem beats.
module tb_inst_block_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cfg_base_addr;
  logic [9:0]  cfg_block_len;
  logic [9:0]  cfg_num_blocks;
  logic        imem_wr_start;
  logic        imem_wr_done;
  logic        imem_wr_data_valid;
  logic [63:0] imem_wr_data;
  logic [0:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        fetch_busy;
  logic        all_blocks_done;
  logic        rresp_err;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] perf_beat_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  inst_block_fetcher dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_block_len     (cfg_block_len),
    .cfg_num_blocks    (cfg_num_blocks),
    .imem_wr_start     (imem_wr_start),
    .imem_wr_done      (imem_wr_done),
    .imem_wr_data_valid(imem_wr_data_valid),
    .imem_wr_data      (imem_wr_data),
    .m_axi_arid        (m_axi_arid),
    .m_axi_araddr      (m_axi_araddr),
    .m_axi_arlen       (m_axi_arlen),
    .m_axi_arsize      (m_axi_arsize),
    .m_axi_arburst     (m_axi_arburst),
    .m_axi_arvalid     (m_axi_arvalid),
    .m_axi_arready     (m_axi_arready),
    .m_axi_rdata       (m_axi_rdata),
    .m_axi_rresp       (m_axi_rresp),
    .m_axi_rlast       (m_axi_rlast),
    .m_axi_rvalid      (m_axi_rvalid),
    .m_axi_rready      (m_axi_rready),
`ifdef INST_FETCH_PERF_CNT_EN
    .perf_beat_cnt     (perf_beat_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
`endif
    .fetch_busy        (fetch_busy),
    .all_blocks_done   (all_blocks_done),
    .rresp_err         (rresp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         ar_exp[$];
  logic [63:0] data_exp[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          beat_total = 0;
  int          err_at = -1;
  bit          stall_en = 1'b0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_data(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) data_exp.push_back(mem_word(base + 32'(i * 8)));
  endtask

  // AXI slave: drives at negedge+1, so every handshake it sets up is known before the posedge
  initial begin : slave
    bit          r_pend;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    int          r_idx;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    ar_t         e;
    r_pend = 0; r_addr = '0; r_len = '0; r_idx = 0;
    prev_wait = 0; prev_addr = '0; prev_len = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      #1;
      m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = '0; m_axi_rdata = '0;
      if (reset) begin
        r_pend = 0; prev_wait = 0; m_axi_arready = 0;
      end else begin
        if (r_pend) begin
          m_axi_rvalid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
          m_axi_rdata  = mem_word(r_addr + 32'(r_idx * 8));
          m_axi_rlast  = (r_idx == int'(r_len));
          m_axi_rresp  = (beat_total == err_at) ? 2'b10 : 2'b00;
          if (m_axi_rvalid && m_axi_rready) begin
            beat_total++;
            r_idx++;
            if (m_axi_rlast) r_pend = 0;
          end
        end
        if (prev_wait) begin
          chk("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
          chk("ar_hold_addr", 64'(m_axi_araddr), 64'(prev_addr));
          chk("ar_hold_len", 64'(m_axi_arlen), 64'(prev_len));
        end
        m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_wait = m_axi_arvalid && !m_axi_arready;
        prev_addr = m_axi_araddr;
        prev_len  = m_axi_arlen;
        if (m_axi_arvalid && m_axi_arready) begin
          if (ar_exp.size() == 0) begin
            chk("unexpected_ar", 64'(m_axi_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = ar_exp.pop_front();
            chk("araddr", 64'(m_axi_araddr), 64'(e.addr));
            chk("arlen", 64'(m_axi_arlen), 64'(e.len));
          end
          r_pend = 1; r_addr = m_axi_araddr; r_len = m_axi_arlen; r_idx = 0;
        end
      end
    end
  end

  // imem-side monitor: pops one expected beat per valid and counts done pulses
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (imem_wr_data_valid) begin
          if (data_exp.size() == 0) chk("extra_beat", imem_wr_data, 64'hDEAD_DEAD_DEAD_DEAD);
          else chk("beat_data", imem_wr_data, data_exp.pop_front());
        end
        if (imem_wr_done) done_cnt++;
      end
    end
  end

  task automatic do_start(input logic [31:0] base, input logic [9:0] len, input logic [9:0] nb);
    @(negedge clk);
    cfg_base_addr = base; cfg_block_len = len; cfg_num_blocks = nb; start = 1;
    @(negedge clk);
    start = 0;
    beat_total = 0;
  endtask

  task automatic pulse_wr_start();
    @(negedge clk);
    imem_wr_start = 1;
    @(negedge clk);
    imem_wr_start = 0;
  endtask

  // Waits for the next done pulse (bounded), then checks it lasted one cycle
  task automatic wait_done(input string tag);
    int target;
    bit seen;
    target = done_cnt + 1;
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      #3;
      if (done_cnt >= target) seen = 1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    #3;
    chk({tag, "_done_one_cycle"}, 64'(imem_wr_done), 64'd0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_ar_left"}, 64'(ar_exp.size()), 64'd0);
    chk({tag, "_beats_left"}, 64'(data_exp.size()), 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    chk({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
    chk({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
    chk({tag, "_arid"}, 64'(m_axi_arid), 64'd0);
    chk({tag, "_arsize"}, 64'(m_axi_arsize), 64'd3);
    chk({tag, "_arburst"}, 64'(m_axi_arburst), 64'd1);
    chk({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
    chk({tag, "_wr_valid"}, 64'(imem_wr_data_valid), 64'd0);
    chk({tag, "_wr_data"}, imem_wr_data, 64'd0);
    chk({tag, "_wr_done"}, 64'(imem_wr_done), 64'd0);
    chk({tag, "_busy"}, 64'(fetch_busy), 64'd0);
    chk({tag, "_all_done"}, 64'(all_blocks_done), 64'd0);
    chk({tag, "_rresp_err"}, 64'(rresp_err), 64'd0);
  endtask

  initial begin : stimulus
    bit seen;
    reset = 1; start = 0; imem_wr_start = 0;
    cfg_base_addr = '0; cfg_block_len = '0; cfg_num_blocks = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    #3;
    chk_idle_outputs("reset");

    // Two contiguous 8-beat blocks
    ar_exp.push_back('{32'h1000, 8'd7});
    ar_exp.push_back('{32'h1040, 8'd7});
    push_data(32'h1000, 16);
    do_start(32'h1000, 10'd8, 10'd2);
    #3;
    chk("two_blk_busy_after_start", 64'(fetch_busy), 64'd1);
    pulse_wr_start();
    wait_done("two_blk_b0");
    chk("two_blk_mid_all_done", 64'(all_blocks_done), 64'd0);
    chk("two_blk_mid_busy", 64'(fetch_busy), 64'd1);
    chk("two_blk_mid_beats", 64'(data_exp.size()), 64'd8);
    pulse_wr_start();
    wait_done("two_blk_b1");
    chk("two_blk_all_done", 64'(all_blocks_done), 64'd1);
    chk("two_blk_busy", 64'(fetch_busy), 64'd0);
    chk("two_blk_done_cnt", 64'(done_cnt), 64'd2);
    chk_drained("two_blk");

    // 40-beat block split by the max burst length
    ar_exp.push_back('{32'h2000, 8'd15});
    ar_exp.push_back('{32'h2080, 8'd15});
    ar_exp.push_back('{32'h2100, 8'd7});
    push_data(32'h2000, 40);
    do_start(32'h2000, 10'd40, 10'd1);
    #3;
    chk("split_all_done_cleared", 64'(all_blocks_done), 64'd0);
    pulse_wr_start();
    wait_done("split");
    chk("split_done_cnt", 64'(done_cnt), 64'd3);
    chk("split_all_done", 64'(all_blocks_done), 64'd1);
    chk_drained("split");

    // Block straddling a 4KB page edge
    ar_exp.push_back('{32'h0FF0, 8'd1});
    ar_exp.push_back('{32'h1000, 8'd5});
    push_data(32'h0FF0, 8);
    do_start(32'h0FF0, 10'd8, 10'd1);
    pulse_wr_start();
    wait_done("page4k");
    chk_drained("page4k");

    // Random AR/R stalls
    stall_en = 1;
    ar_exp.push_back('{32'h3000, 8'd15});
    ar_exp.push_back('{32'h3080, 8'd3});
    push_data(32'h3000, 20);
    do_start(32'h3000, 10'd20, 10'd1);
    pulse_wr_start();
    wait_done("stall");
    chk_drained("stall");
    chk("stall_rresp_err", 64'(rresp_err), 64'd0);
    stall_en = 0;

    // SLVERR on the third beat: forwarded, block completes, error sticks
    ar_exp.push_back('{32'h4000, 8'd3});
    push_data(32'h4000, 4);
    do_start(32'h4000, 10'd4, 10'd1);
    err_at = 2;
    pulse_wr_start();
    wait_done("slverr");
    err_at = -1;
    chk("slverr_sticky", 64'(rresp_err), 64'd1);
    chk("slverr_all_done", 64'(all_blocks_done), 64'd1);
    chk_drained("slverr");
    do_start(32'h4000, 10'd0, 10'd1);
    #3;
    chk("slverr_cleared_by_start", 64'(rresp_err), 64'd0);
    chk("slverr_restart_busy", 64'(fetch_busy), 64'd1);

    // Zero-length block: done right away, no AR traffic
    pulse_wr_start();
    #3;
    chk("len0_done_now", 64'(imem_wr_done), 64'd1);
    chk("len0_no_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(negedge clk);
    #3;
    chk("len0_all_done", 64'(all_blocks_done), 64'd1);
    chk("len0_busy", 64'(fetch_busy), 64'd0);
    chk_drained("len0");

    // Zero blocks: finishes without arming
    do_start(32'h5000, 10'd8, 10'd0);
    #3;
    chk("nb0_all_done", 64'(all_blocks_done), 64'd1);
    chk("nb0_busy", 64'(fetch_busy), 64'd0);

    // Reset in the middle of a data burst
    ar_exp.push_back('{32'h6000, 8'd7});
    push_data(32'h6000, 8);
    do_start(32'h6000, 10'd8, 10'd1);
    pulse_wr_start();
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      #3;
      if (m_axi_rready) seen = 1;
    end
    chk("rst_reached_data", 64'(seen), 64'd1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #3;
    chk_idle_outputs("mid_rst");
    ar_exp.delete();
    data_exp.delete();
    repeat (3) @(negedge clk);
    #3;
    chk("mid_rst_stays_idle", 64'(m_axi_arvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
